// File: rtl/dct_pkg.sv
// -----------------------------------------------------------------------------
// dct_pkg
// Shared types and constants for the DCT coefficient collector.
//   COEF_W  : coefficient width (two's complement)
//   N, BLK  : block dimension and coefficients per block
//   IDX_W   : width of a coefficient index within a block
//   bank_state_t : life cycle of one ping-pong bank
//   rd_state_t   : read-side sequencer states
//   ZIGZAG  : scan index -> raster address table for an 8x8 block
// Used by the optional zigzag read order (macro DCT_ZIGZAG_EN).
// -----------------------------------------------------------------------------
package dct_pkg;

  localparam int COEF_W = 12;
  localparam int N      = 8;
  localparam int BLK    = N * N;
  localparam int IDX_W  = 6;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } rd_state_t;

  localparam logic [IDX_W-1:0] ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/dct_zigzag_rom.sv
// -----------------------------------------------------------------------------
// dct_zigzag_rom
// Combinational lookup: zigzag scan index -> raster address in an 8x8 block.
// Only present when DCT_ZIGZAG_EN is defined; the raster build needs no ROM.
// Ports:
//   i_idx  in  6  scan index 0..63
//   o_addr out 6  raster address of that scan position
// -----------------------------------------------------------------------------
`ifdef DCT_ZIGZAG_EN
module dct_zigzag_rom
  import dct_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  output logic [IDX_W-1:0] o_addr
);

  assign o_addr = ZIGZAG[i_idx];

endmodule
`endif

// File: rtl/dct_coef_collector.sv
// -----------------------------------------------------------------------------
// dct_coef_collector
// Sink for the 2-D DCT output stream. Coefficients arrive in raster order and
// are captured into a two-bank ping-pong buffer; each completed block is
// replayed on a valid/ready stream. One full block of back-pressure is
// absorbed; beyond that incoming coefficients are dropped and a sticky
// overflow flag is raised.
// Configuration macro: DCT_ZIGZAG_EN -- replay in zigzag scan order
// (coef_idx is then the scan index); otherwise raster order.
// Ports:
//   clock      in   1       single clock, posedge
//   reset      in   1       synchronous, active-high
//   ready_out  in   1       DCT coefficient strobe
//   dct_2d     in   COEF_W  DCT coefficient
//   coef_out   out  COEF_W  buffered coefficient
//   coef_idx   out  6       position of coef_out in the output order
//   out_valid  out  1       output beat valid
//   out_ready  in   1       downstream accept
//   out_last   out  1       last beat of a block (coef_idx == 63)
//   overflow   out  1       sticky, a coefficient was dropped
// -----------------------------------------------------------------------------
module dct_coef_collector
  import dct_pkg::*;
#(
  parameter int COEF_W = dct_pkg::COEF_W,
  parameter int N      = dct_pkg::N
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ready_out,
  input  logic [COEF_W-1:0] dct_2d,
  output logic [COEF_W-1:0] coef_out,
  output logic [IDX_W-1:0]  coef_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              overflow
);

  localparam int              BLK_SZ = N * N;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(BLK_SZ - 1);

  // Storage and bank bookkeeping
  logic [COEF_W-1:0] r_mem [2][BLK_SZ];
  bank_state_t       r_bank_st [2];

  // Write side
  logic             r_wr_bank;
  logic [IDX_W-1:0] r_wr_cnt;
  logic             r_overflow;

  // Read side
  rd_state_t         r_rd_state;
  rd_state_t         w_rd_next;
  logic              r_rd_bank;
  logic [IDX_W-1:0]  r_rd_cnt;
  logic [COEF_W-1:0] r_coef;

  logic             w_wr_accept;
  logic             w_wr_drop;
  logic             w_wr_done;
  logic             w_xfer;
  logic             w_rd_last;
  logic             w_rd_fetch;
  logic [IDX_W-1:0] w_fetch_cnt;
  logic [IDX_W-1:0] w_rd_addr;

  // A bank takes writes only until it is complete; FULL or DRAINING at the
  // write pointer means both banks are occupied.
  assign w_wr_accept = ready_out &&
                       (r_bank_st[r_wr_bank] == EMPTY || r_bank_st[r_wr_bank] == FILLING);
  assign w_wr_drop   = ready_out && !w_wr_accept;
  assign w_wr_done   = w_wr_accept && (r_wr_cnt == LAST);

  assign w_xfer      = (r_rd_state == STREAM) && out_ready;
  assign w_rd_last   = w_xfer && (r_rd_cnt == LAST);

  // Prefetch: the entry after the one being accepted is read on the same edge
  // so the next beat is presented without a bubble.
  assign w_rd_fetch  = (r_rd_state == LOAD) || (w_xfer && !w_rd_last);
  assign w_fetch_cnt = (r_rd_state == LOAD) ? '0 : r_rd_cnt + 1'b1;

`ifdef DCT_ZIGZAG_EN
  dct_zigzag_rom u_zigzag_rom (
    .i_idx  (w_fetch_cnt),
    .o_addr (w_rd_addr)
  );
`else
  assign w_rd_addr = w_fetch_cnt;
`endif

  // NOTE: the buffer array has no reset; stale contents are never observed
  // because bank states gate every read, and a reset network on 128 words
  // would only cost area and timing.
  always_ff @(posedge clock) begin
    if (w_wr_accept) begin
      r_mem[r_wr_bank][r_wr_cnt] <= dct_2d;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every block
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_cnt   <= '0;
      r_wr_bank  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        if (w_wr_done) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt  <= r_wr_cnt + 1'b1;
        end
      end
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Read and write never act on the same bank in one cycle: writes need
  // EMPTY/FILLING, reads need FULL/DRAINING, so both updates can coexist.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bank_st[0] <= EMPTY;
      r_bank_st[1] <= EMPTY;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_rd_last && r_rd_bank == 1'(b)) begin
          r_bank_st[b] <= EMPTY;
        end else if (r_rd_state == LOAD && r_rd_bank == 1'(b)) begin
          r_bank_st[b] <= DRAINING;
        end else if (w_wr_accept && r_wr_bank == 1'(b)) begin
          r_bank_st[b] <= w_wr_done ? FULL : FILLING;
        end
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      IDLE:    if (r_bank_st[r_rd_bank] == FULL) w_rd_next = LOAD;
      LOAD:    w_rd_next = STREAM;
      STREAM: begin
        if (w_rd_last) begin
          w_rd_next = (r_bank_st[~r_rd_bank] == FULL) ? LOAD : IDLE;
        end
      end
      default: w_rd_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_state <= IDLE;
      r_rd_bank  <= 1'b0;
      r_rd_cnt   <= '0;
      r_coef     <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      if (w_rd_fetch) begin
        r_coef <= r_mem[r_rd_bank][w_rd_addr];
      end
      if (w_rd_last) begin
        r_rd_cnt  <= '0;
        r_rd_bank <= ~r_rd_bank;
      end else if (w_xfer) begin
        r_rd_cnt  <= r_rd_cnt + 1'b1;
      end
    end
  end

  // r_rd_cnt only advances on a transfer, so the presented beat holds while
  // the downstream stalls.
  assign out_valid = (r_rd_state == STREAM);
  assign coef_out  = r_coef;
  assign coef_idx  = r_rd_cnt;
  assign out_last  = out_valid && (r_rd_cnt == LAST);
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_dct_coef_collector.sv
// -----------------------------------------------------------------------------
// tb_dct_coef_collector
// Directed bench for dct_coef_collector. A block-level model (queue of
// completed blocks, at most two resident) predicts every accepted beat, the
// overflow flag and drops; literal checks pin latency, gaps and values.
// Build with +define+DCT_ZIGZAG_EN to check the zigzag replay order.
// -----------------------------------------------------------------------------
module tb_dct_coef_collector;

  localparam int CW = 12;

  logic          clock = 1'b0;
  logic          reset;
  logic          ready_out;
  logic [CW-1:0] dct_2d;
  logic [CW-1:0] coef_out;
  logic [5:0]    coef_idx;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          overflow;

  dct_coef_collector dut (
    .clock     (clock),
    .reset     (reset),
    .ready_out (ready_out),
    .dct_2d    (dct_2d),
    .coef_out  (coef_out),
    .coef_idx  (coef_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output position -> raster address, derived by walking the anti-diagonals.
  function automatic int zz(input int i);
`ifdef DCT_ZIGZAG_EN
    int n, r, c;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      for (int t = 0; t < 8; t++) begin
        r = (s % 2 == 0) ? ((s < 8 ? s : 7) - t) : ((s < 8 ? 0 : s - 7) + t);
        c = s - r;
        if (r >= 0 && r < 8 && c >= 0 && c < 8) begin
          if (n == i) return r * 8 + c;
          n++;
        end
      end
    end
    return 0;
`else
    return i;
`endif
  endfunction

  // ---------------- block-level model + per-cycle compare ----------------
  logic [CW-1:0] val_q[$];      // completed, not yet fully emitted blocks
  logic [CW-1:0] part [64];     // block being written
  int            nblk    = 0;
  int            m_wcnt  = 0;
  int            m_beat  = 0;
  logic          m_ovf   = 1'b0;
  int            xfer_cnt  = 0;
  int            stall_cnt = 0; // cycles with a block buffered but no beat shown
  logic          prev_stall = 1'b0;
  logic [CW-1:0] prev_coef;
  logic [5:0]    prev_idx;
  logic          prev_last;
  logic          acc;

  always @(negedge clock) begin
    if (reset) begin
      val_q.delete();
      nblk = 0; m_wcnt = 0; m_beat = 0; m_ovf = 1'b0; prev_stall = 1'b0;
    end else begin
      check("overflow", overflow, m_ovf);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_coef", coef_out, prev_coef);
        check("hold_idx", coef_idx, prev_idx);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid && nblk == 0) check("phantom_valid", out_valid, 0);
      if (!out_valid && nblk > 0) stall_cnt++;
      acc = ready_out && (nblk < 2);
      if (out_valid && out_ready && nblk > 0) begin
        check("beat_coef", coef_out, val_q[zz(m_beat)]);
        check("beat_idx", coef_idx, m_beat);
        check("beat_last", out_last, m_beat == 63);
        xfer_cnt++;
        if (m_beat == 63) begin
          repeat (64) void'(val_q.pop_front());
          nblk--;
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
      if (ready_out) begin
        if (acc) begin
          part[m_wcnt] = dct_2d;
          m_wcnt++;
          if (m_wcnt == 64) begin
            for (int i = 0; i < 64; i++) val_q.push_back(part[i]);
            nblk++;
            m_wcnt = 0;
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_coef  = coef_out;
      prev_idx   = coef_idx;
      prev_last  = out_last;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic toggle_mode = 1'b0;

  task automatic cyc();
    @(posedge clock);
    #1;
    if (toggle_mode) out_ready = ~out_ready;
  endtask

  task automatic write_block(input int base, input int step, input int duty);
    for (int k = 0; k < 64; k++) begin
      for (int g = 0; g < 20 && duty < 100 && $urandom_range(0, 99) >= duty; g++) begin
        ready_out = 1'b0;
        cyc();
      end
      ready_out = 1'b1;
      dct_2d    = CW'(base + k * step);
      cyc();
    end
    ready_out = 1'b0;
  endtask

  // Called right after the edge that captured coefficient 63, read side idle.
  task automatic lat_check(input string tag);
    check({tag, "_lat0"}, out_valid, 0);
    cyc();
    check({tag, "_lat1"}, out_valid, 0);
    cyc();
    check({tag, "_lat2"}, out_valid, 1);
    check({tag, "_idx0"}, coef_idx, 0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((nblk != 0 || out_valid) && n < 600) begin
      cyc();
      n++;
    end
    check({tag, "_drained"}, (nblk == 0 && !out_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int s_x, s_s, n;
  logic [CW-1:0] exp2, exp3;

  initial begin
    reset = 1'b1; ready_out = 1'b0; dct_2d = '0; out_ready = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_coef", coef_out, 0);
    check("rst_idx", coef_idx, 0);
    check("rst_last", out_last, 0);
    check("rst_ovf", overflow, 0);

    // 1) single block, coefficient k = k
    s_x = xfer_cnt; s_s = stall_cnt;
    write_block(0, 1, 100);
    lat_check("t1");
    check("t1_b0", coef_out, 0);
    cyc(); check("t1_b1", coef_out, 1);
`ifdef DCT_ZIGZAG_EN
    exp2 = 12'd8;  exp3 = 12'd16;
`else
    exp2 = 12'd2;  exp3 = 12'd3;
`endif
    cyc(); check("t1_b2", coef_out, exp2);
    cyc(); check("t1_b3", coef_out, exp3);
    drain("t1");
    check("t1_beats", xfer_cnt - s_x, 64);
    check("t1_stalls", stall_cnt - s_s, 2);
    check("t1_ovf", overflow, 0);

    // 2) back-to-back extreme blocks
    s_x = xfer_cnt; s_s = stall_cnt;
    write_block(-2048, 0, 100);
    write_block(2047, 0, 100);
    check("t2_neg", coef_out, 12'h800);
    cyc(); cyc();
    check("t2_gap", out_valid, 0);
    cyc();
    check("t2_pos_valid", out_valid, 1);
    check("t2_pos", coef_out, 12'h7FF);
    drain("t2");
    check("t2_beats", xfer_cnt - s_x, 128);
    check("t2_stalls", stall_cnt - s_s, 3);

    // 3) stalled sink, third block overflows
    s_x = xfer_cnt;
    out_ready = 1'b0;
    write_block(100, 1, 100);
    write_block(200, 1, 100);
    check("t3_ovf_before", overflow, 0);
    check("t3_held_valid", out_valid, 1);
    check("t3_held_coef", coef_out, 100);
    write_block(300, 1, 100);
    check("t3_ovf_after", overflow, 1);
    out_ready = 1'b1;
    drain("t3");
    check("t3_beats", xfer_cnt - s_x, 128);

    // 4) out_ready toggling
    s_x = xfer_cnt;
    toggle_mode = 1'b1;
    write_block(-500, 17, 100);
    drain("t4");
    toggle_mode = 1'b0;
    out_ready = 1'b1;
    check("t4_beats", xfer_cnt - s_x, 64);

    // 5) sparse input strobe
    s_x = xfer_cnt; s_s = stall_cnt;
    write_block(0, 1, 30);
    lat_check("t5");
    check("t5_b0", coef_out, 0);
    drain("t5");
    check("t5_beats", xfer_cnt - s_x, 64);
    check("t5_stalls", stall_cnt - s_s, 2);

    // 6a) reset after 40 writes
    for (int k = 0; k < 40; k++) begin
      ready_out = 1'b1; dct_2d = CW'(k + 50); cyc();
    end
    ready_out = 1'b0;
    reset = 1'b1; cyc(); reset = 1'b0;
    check("t6a_valid", out_valid, 0);
    check("t6a_ovf_clr", overflow, 0);
    s_x = xfer_cnt;
    write_block(1000, 5, 100);
    lat_check("t6a");
    check("t6a_b0", coef_out, 12'd1000);
    drain("t6a");
    check("t6a_beats", xfer_cnt - s_x, 64);

    // 6b) reset during streaming beat 10
    s_x = xfer_cnt;
    write_block(256, 1, 100);
    n = 0;
    while (xfer_cnt - s_x < 10 && n < 200) begin cyc(); n++; end
    check("t6b_reached", xfer_cnt - s_x, 10);
    reset = 1'b1; cyc();
    check("t6b_valid", out_valid, 0);
    check("t6b_idx", coef_idx, 0);
    reset = 1'b0;
    s_x = xfer_cnt;
    write_block(-7, -3, 100);
    lat_check("t6b");
    check("t6b_b0", coef_out, 12'hFF9);
    drain("t6b");
    check("t6b_beats", xfer_cnt - s_x, 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
